clock_ctrl: RTL and testbench

//  Run/halt/single-step controller for the CPU clock. Drives stop_clk into the clock

---
 rtl/clock_ctrl.sv | 132 +++++++++++++
 tb/tb_clock_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_ctrl.sv
// Run/halt/step controller for the CPU clock; freezes the divider only with cpu_clk HIGH.
// Latency: stop_clk asserts on the posedge that samples the cpu_clk rise; no backpressure, commands are single-cycle pulses.
module clock_ctrl #(
  parameter int ADDR_W       = 16,
  parameter bit RUN_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              cpu_clk,
  input  logic              run,
  input  logic              halt,
  input  logic              step,
  input  logic [15:0]       step_n,
  input  logic              bkpt_en,
  input  logic [ADDR_W-1:0] bkpt_addr,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              stop_clk,
  output logic              halted,
  output logic              bkpt_hit,
  output logic [31:0]       cycle_count
);

  typedef enum logic [1:0] {
    ST_HALTED    = 2'd0,
    ST_RUNNING   = 2'd1,
    ST_HALT_PEND = 2'd2,
    ST_STEPPING  = 2'd3
  } state_t;

  localparam state_t ST_RESET = RUN_ON_RESET ? ST_RUNNING : ST_HALTED;

  state_t      state, state_nxt;
  logic [15:0] remaining, remaining_nxt;
  logic        bkpt_hit_q, bkpt_hit_nxt;
  logic        stop_clk_q;
  logic        cpu_clk_q;
  logic [31:0] cycle_count_q;
  logic        rise;
  logic        bkpt_match;

  assign rise       = cpu_clk & ~cpu_clk_q;
  assign bkpt_match = bkpt_en && (cpu_addr == bkpt_addr);

  // cpu_clk_q resets HIGH to match the divider so the first sample is not a false rise.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state      <= ST_RESET;
      remaining  <= 16'd0;
      bkpt_hit_q <= 1'b0;
      stop_clk_q <= (ST_RESET == ST_HALTED);
      cpu_clk_q  <= 1'b1;
    end else begin
      state      <= state_nxt;
      remaining  <= remaining_nxt;
      bkpt_hit_q <= bkpt_hit_nxt;
      stop_clk_q <= (state_nxt == ST_HALTED);
      cpu_clk_q  <= cpu_clk;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cycle_count_q <= 32'd0;
    end else if (rise) begin
      cycle_count_q <= cycle_count_q + 32'd1;
    end
  end

  // Every stop decision is taken on rise, so the divider is frozen with cpu_clk HIGH.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    bkpt_hit_nxt  = bkpt_hit_q;
    case (state)
      ST_HALTED: begin
        if (!halt) begin
          if (step) begin
            state_nxt     = ST_STEPPING;
            remaining_nxt = (step_n == 16'd0) ? 16'd1 : step_n;
            bkpt_hit_nxt  = 1'b0;
          end else if (run) begin
            state_nxt    = ST_RUNNING;
            bkpt_hit_nxt = 1'b0;
          end
        end
      end
      ST_RUNNING: begin
        if (rise && bkpt_match) begin
          state_nxt    = ST_HALTED;
          bkpt_hit_nxt = 1'b1;
        end else if (halt) begin
          state_nxt = ST_HALT_PEND;
        end
      end
      ST_HALT_PEND: begin
        if (rise) begin
          state_nxt = ST_HALTED;
          if (bkpt_match) begin
            bkpt_hit_nxt = 1'b1;
          end
        end
      end
      ST_STEPPING: begin
        if (rise && bkpt_match) begin
          state_nxt     = ST_HALTED;
          bkpt_hit_nxt  = 1'b1;
          remaining_nxt = 16'd0;
        end else if (rise && (remaining == 16'd1)) begin
          state_nxt     = ST_HALTED;
          remaining_nxt = 16'd0;
        end else if (halt) begin
          state_nxt     = ST_HALT_PEND;
          remaining_nxt = 16'd0;
        end else if (rise) begin
          remaining_nxt = remaining - 16'd1;
        end
      end
      default: begin
        state_nxt     = ST_RESET;
        remaining_nxt = 16'd0;
      end
    endcase
  end

  always_comb begin
    stop_clk    = stop_clk_q;
    halted      = (state == ST_HALTED);
    bkpt_hit    = bkpt_hit_q;
    cycle_count = cycle_count_q;
  end

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl with a behavioural clock divider (half period = CLK_SEL+1 clk cycles).
module tb_clock_ctrl;

  localparam int CLK_SEL = 3;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        cpu_clk = 1'b1;
  logic        run = 1'b0;
  logic        halt = 1'b0;
  logic        step = 1'b0;
  logic [15:0] step_n = 16'd0;
  logic        bkpt_en = 1'b0;
  logic [15:0] bkpt_addr = 16'd0;
  logic [15:0] cpu_addr;
  logic        stop_clk;
  logic        halted;
  logic        bkpt_hit;
  logic [31:0] cycle_count;

  int          checks = 0;
  int          failures = 0;
  int          tb_rises = 0;
  int          div_cnt = 0;
  logic [15:0] addr_cnt = 16'd0;
  logic [15:0] addr_ofs = 16'd0;

  assign cpu_addr = addr_cnt + addr_ofs;

  clock_ctrl #(.ADDR_W(16), .RUN_ON_RESET(1'b1)) dut (
    .clk         (clk),
    .arst        (arst),
    .cpu_clk     (cpu_clk),
    .run         (run),
    .halt        (halt),
    .step        (step),
    .step_n      (step_n),
    .bkpt_en     (bkpt_en),
    .bkpt_addr   (bkpt_addr),
    .cpu_addr    (cpu_addr),
    .stop_clk    (stop_clk),
    .halted      (halted),
    .bkpt_hit    (bkpt_hit),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  // Divider model: toggles on negedge clk, resets HIGH, freezes while stop_clk is set.
  // The CPU address advances on each cpu_clk fall so it is stable at the rise.
  always @(negedge clk or posedge arst) begin
    if (arst) begin
      div_cnt  = 0;
      cpu_clk  = 1'b1;
      tb_rises = 0;
    end else if (!stop_clk) begin
      if (div_cnt == CLK_SEL) begin
        div_cnt = 0;
        cpu_clk = ~cpu_clk;
        if (cpu_clk) tb_rises = tb_rises + 1;
        else         addr_cnt = addr_cnt + 16'd1;
      end else begin
        div_cnt = div_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic pulse(input logic h, input logic s, input logic r);
    halt = h;
    step = s;
    run  = r;
    @(posedge clk);
    #1;
    halt = 1'b0;
    step = 1'b0;
    run  = 1'b0;
  endtask

  task automatic wait_rises(input int target);
    bool_loop: for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (tb_rises >= target) return;
    end
    chk("rise_timeout", tb_rises, target);
  endtask

  task automatic wait_halted();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (halted) return;
    end
    chk("halt_timeout", {31'd0, halted}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stop_clk", {31'd0, stop_clk}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_bkpt_hit", {31'd0, bkpt_hit}, 32'd0);
    chk("rst_cycle_count", cycle_count, 32'd0);
    arst = 1'b0;

    // Free run counts every rise.
    wait_rises(5);
    chk("run_count5", cycle_count, 32'd5);

    // Halt waits for the next rise and freezes with cpu_clk HIGH.
    pulse(1'b1, 1'b0, 1'b0);
    chk("halt_pend_stop_clk", {31'd0, stop_clk}, 32'd0);
    wait_rises(6);
    chk("halt_stop_clk", {31'd0, stop_clk}, 32'd1);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    repeat (30) @(posedge clk);
    #1;
    chk("halt_cpu_clk_high", {31'd0, cpu_clk}, 32'd1);
    chk("halt_count_frozen", cycle_count, 32'd6);

    // Step 3 cycles.
    step_n = 16'd3;
    pulse(1'b0, 1'b1, 1'b0);
    chk("step3_running", {31'd0, halted}, 32'd0);
    wait_halted();
    chk("step3_count", cycle_count, 32'd9);
    chk("step3_model_rises", tb_rises, 32'd9);
    chk("step3_cpu_clk_high", {31'd0, cpu_clk}, 32'd1);

    // step_n == 0 behaves as a single step.
    step_n = 16'd0;
    pulse(1'b0, 1'b1, 1'b0);
    wait_halted();
    chk("step0_count", cycle_count, 32'd10);

    // halt + step + run together while running: halt wins.
    pulse(1'b0, 1'b0, 1'b1);
    chk("run_stop_clk", {31'd0, stop_clk}, 32'd0);
    wait_rises(12);
    step_n = 16'd5;
    pulse(1'b1, 1'b1, 1'b1);
    chk("combo_not_halted", {31'd0, halted}, 32'd0);
    wait_rises(13);
    chk("combo_halted", {31'd0, halted}, 32'd1);
    chk("combo_count", cycle_count, 32'd13);

    // Address breakpoint: addresses 0x00FE, 0x00FF, 0x0100 on the next three rises.
    addr_ofs  = 16'h00FD - addr_cnt;
    bkpt_addr = 16'h0100;
    bkpt_en   = 1'b1;
    pulse(1'b0, 1'b0, 1'b1);
    wait_halted();
    chk("bkpt_halted", {31'd0, halted}, 32'd1);
    chk("bkpt_hit", {31'd0, bkpt_hit}, 32'd1);
    chk("bkpt_count", cycle_count, 32'd16);
    chk("bkpt_addr_at_stop", {16'd0, cpu_addr}, 32'h0000_0100);
    pulse(1'b0, 1'b0, 1'b1);
    chk("bkpt_cleared_by_run", {31'd0, bkpt_hit}, 32'd0);
    bkpt_en = 1'b0;
    pulse(1'b1, 1'b0, 1'b0);
    wait_halted();
    chk("rehalt_count", cycle_count, 32'd17);

    // Reset in the middle of a 5-cycle step.
    step_n = 16'd5;
    pulse(1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("midstep_not_halted", {31'd0, halted}, 32'd0);
    arst = 1'b1;
    #2;
    chk("arst_stop_clk", {31'd0, stop_clk}, 32'd0);
    chk("arst_halted", {31'd0, halted}, 32'd0);
    chk("arst_cycle_count", cycle_count, 32'd0);
    repeat (2) @(negedge clk);
    #2;
    arst = 1'b0;
    wait_rises(1);
    chk("post_arst_count", cycle_count, 32'd1);

    // Counter wrap.
    pulse(1'b1, 1'b0, 1'b0);
    wait_halted();
    chk("wrap_pre_halt_count", cycle_count, 32'd2);
    force dut.cycle_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_count_q;
    #1;
    chk("wrap_preload", cycle_count, 32'hFFFF_FFFF);
    pulse(1'b0, 1'b0, 1'b1);
    wait_rises(3);
    chk("wrap_to_zero", cycle_count, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
